// File: rtl/iq_sample_player.sv
// iq_sample_player: multi-channel IQ sample memory with paced one-shot/loop playback; define IQ_PLAYER_LOOP_CNT_EN to add the o_loop_cnt pass counter
module iq_sample_player #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int DEPTH = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [NUM_CH*2*DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W:0]            i_len,
  input  logic [15:0]                i_div,
  input  logic                       i_loop,
  input  logic                       i_start,
  input  logic                       i_stop,
  output logic [NUM_CH*DATA_W-1:0]   o_I_data,
  output logic [NUM_CH*DATA_W-1:0]   o_Q_data,
  output logic [NUM_CH-1:0]          o_valid,
  output logic                       o_busy,
  output logic                       o_done
`ifdef IQ_PLAYER_LOOP_CNT_EN
  ,
  output logic [15:0]                o_loop_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ARM, PLAY} state_t;
  localparam int MEM_W = NUM_CH * 2 * DATA_W;
  logic [MEM_W-1:0] r_mem [DEPTH];
  logic [MEM_W-1:0] r_rd;
  state_t r_state;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W:0] r_len;
  logic [15:0] r_div, r_cnt, w_per_m1;
  logic r_loop, r_fin, w_start_ok, w_strobe, w_last;
  logic [NUM_CH*DATA_W-1:0] w_i, w_q;

  assign w_start_ok = r_state == IDLE && i_start && !i_stop && i_len != '0 && i_len <= (ADDR_W+1)'(DEPTH);
  assign w_per_m1 = r_div > 16'd1 ? r_div - 16'd1 : '0;
  assign w_strobe = !i_stop && (r_state == ARM || (r_state == PLAY && !r_fin && r_cnt == w_per_m1));
  assign w_last = w_strobe && {1'b0, r_addr} == r_len - 1'b1;
  assign w_addr_nxt = w_start_ok || w_last ? '0 : w_strobe ? r_addr + 1'b1 : r_addr;
  assign o_busy = r_state != IDLE;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign w_i[c*DATA_W +: DATA_W] = r_rd[2*c*DATA_W +: DATA_W];
    assign w_q[c*DATA_W +: DATA_W] = r_rd[(2*c+1)*DATA_W +: DATA_W];
  end

  // Sample memory: read-first, the read port always fetches the sample due at the next strobe
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd <= r_mem[w_addr_nxt];
  end

  // Playback FSM: ARM absorbs read latency, PLAY paces strobes, r_fin marks the cycle after a one-shot's last strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_div <= '0;
      r_loop <= 1'b0;
      r_fin <= 1'b0;
      o_valid <= '0;
      o_done <= 1'b0;
      o_I_data <= '0;
      o_Q_data <= '0;
    end else begin
      r_addr <= w_addr_nxt;
      r_cnt <= w_strobe || r_state != PLAY ? '0 : r_cnt + 1'b1;
      r_fin <= w_last && !r_loop;
      o_valid <= {NUM_CH{w_strobe}};
      o_done <= r_state == PLAY && r_fin && !i_stop;
      if (w_strobe) begin
        o_I_data <= w_i;
        o_Q_data <= w_q;
      end
      case (r_state)
        IDLE: if (w_start_ok) begin
          r_state <= ARM;
          r_len <= i_len;
          r_div <= i_div;
          r_loop <= i_loop;
        end
        ARM: r_state <= i_stop ? IDLE : PLAY;
        PLAY: r_state <= i_stop || r_fin ? IDLE : PLAY;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef IQ_PLAYER_LOOP_CNT_EN
  // Completed-pass counter, restarted by each accepted start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_loop_cnt <= '0;
    else if (w_start_ok) o_loop_cnt <= '0;
    else if (w_last) o_loop_cnt <= o_loop_cnt + 1'b1;
  end
`endif
endmodule
